mp_stream_converter: RTL and testbench
======================================

# mp_stream_converter

Pipelined, multi-lane FP4 (E2M1, bias 1) ⇄ FP8 (E4M3, bias 7) precision converter with valid/ready handshaking.
- Direction is selectable per beat, so one instance serves both the widen path (FP4 operands into FP8 adders/multipliers) and the narrow path (FP8 butterfly results back to FP4 storage).
- Downconversion uses round-to-nearest-even, saturates on overflow and flags every overflow and underflow per lane.
- Sits between the butterfly datapath and the sample/twiddle memories of the mixed-precision FFT.

## Interface
- LANES, 4, scalar elements per beat; a complex sample uses 2 lanes in order {real, imag}, real in the higher lane.
- CNT_W, 16, width of the statistics counters.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_mode  in  1  direction: 0 = FP4→FP8 (up), 1 = FP8→FP4 (down).
- in_data  in  8*LANES  up mode: lane i is in_data[4i+3:4i], upper half ignored; down mode: lane i is in_data[8i+7:8i].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_mode  out  1  in_mode of the beat being presented.
- out_data  out  8*LANES  up mode: FP8 lane i at [8i+7:8i]; down mode: FP4 lane i at [4i+3:4i], upper half zero.
- out_ovf  out  LANES  per-lane saturation flag (down mode only).
- out_unf  out  LANES  per-lane underflow flag: nonzero input produced ±0 (down mode only).
- stat_clr  in  1  synchronous clear of both counters.
- ovf_count  out  CNT_W  lanes saturated since reset/clear.
- unf_count  out  CNT_W  lanes underflowed since reset/clear.

## Operation
- Sign is always passed through unchanged, including on zero results.
- Up conversion is exact:
  - exp4 = 00, m = 0 → 0x00 with the sign preserved.
  - exp4 = 00, m = 1 (value 0.5) → exponent 0110, mantissa 000. This is an FP8 normal, not a subnormal.
  - exp4 ≠ 00 → exponent exp4+6, mantissa {m,00}.
  - Up mode never raises any flag.
- Down conversion, with FP8 exponent e and mantissa m[2:0]:
  - e ≤ 4 → ±0. unf is raised if the input was nonzero.
  - e = 5 (magnitude in [0.25, 0.5)): m = 000 → ±0 with unf (tie rounds to even). Otherwise → FP4 subnormal ±0.5, no flag.
  - 6 ≤ e ≤ 9: exp4 = e−6 and mant = m[2]. Round up when m[1] && (m[0] || m[2]).
  - A carry out of the mantissa increments exp4 and clears mant.
  - If that carry would push exp4 past 3, the result saturates to ±6.0 (exp 11, mant 1) and ovf is raised.
  - e ≥ 10, including 1111 → ±6.0 with ovf.
- Pipeline is 2 stages:
  - S1 registers the decoded, rounded lanes, the flags and the mode.
  - S2 is the output register.
- Stall rules:
  - A stage loads when it is empty or its content is leaving in the same cycle.
  - in_ready = !(s1_valid && s2_valid && !out_ready).
  - This gives full throughput with no bubbles, and no combinational path from in_valid to out_valid.
- Mode may differ on every beat. Each beat carries its own mode through the pipe, and no flush is needed.
- Counters:
  - On each output handshake, each counter adds the popcount of its flag vector.
  - Counters saturate at all-ones.
  - If stat_clr coincides with a handshake, the counter becomes the popcount of that beat.

## Timing
- Latency is 2 cycles: a beat accepted at edge N is presented with out_valid high after edge N+2, provided out_ready was high.
- While out_valid && !out_ready, out_data, out_mode, out_ovf and out_unf stay stable. Beats are never dropped or duplicated.
- Under backpressure, up to 2 beats are held in the pipe. in_ready drops in the cycle when both stages are full and out_ready is low.
- Reset values: out_valid = 0, out_data = 0, out_mode = 0, out_ovf = 0, out_unf = 0, counters = 0. in_ready is 1 one cycle after reset deasserts.
- Reset asserted mid-stream discards all in-flight beats immediately (asynchronous). There is no partial output.

## Configuration
- MP_CONV_STATS_EN defined: the ovf_count and unf_count counters and the stat_clr logic are built.
- Not defined: ovf_count and unf_count are tied to 0 and stat_clr is ignored.
- Per-lane out_ovf and out_unf are present in both builds.

## Test plan
- Up, LANES=4, in_data lanes {0x3, 0x1, 0x8, 0xF} → out lanes {0x3C, 0x30, 0x80, 0xCC}, all flags 0, out_valid exactly 2 cycles after the handshake.
- Down, in_data lanes {0x3C, 0x3A, 0x3E, 0x50} → {0x3, 0x2, 0x4, 0x7}, out_ovf = 0b1000 (lane 3), out_unf = 0.
- Down, lanes {0x28, 0xA9, 0x00, 0xF8} → {0x0, 0x9, 0x0, 0xF}, out_unf = 0b0001 (lane 0), out_ovf = 0b1000 (lane 3); with MP_CONV_STATS_EN, both counters read 1.
- Alternate up/down beats back-to-back for 16 beats with random out_ready → every output's out_mode and out_data match a reference model, in order; in_ready only low when both stages are full and out_ready is low.
- Hold out_ready low for 5 cycles with in_valid high → exactly 2 beats are accepted and out_data is held stable; release → beats drain in order with no gaps.
- Assert rst while 2 beats are in flight → out_valid goes to 0 immediately and no stale beat appears after release; with stats enabled, drive 0xFFFF saturating lanes at CNT_W = 4 → ovf_count holds at 15.

Source files
------------

// File: rtl/mp_stream_converter_if.sv
// Handshake bundle for mp_stream_converter: input beat stream, output beat stream
// and per-lane flags. The converter uses the slave modport; the producer/consumer side uses master.
interface mp_stream_converter_if #(
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [8*LANES-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_mode;
  logic [8*LANES-1:0]   out_data;
  logic [LANES-1:0]     out_ovf;
  logic [LANES-1:0]     out_unf;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_ovf, out_unf
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_ovf, out_unf
  );
endinterface

// File: rtl/mp_stream_converter.sv
// Two-stage FP4 (E2M1) <-> FP8 (E4M3) lane converter with valid/ready flow control.
// Define MP_CONV_STATS_EN to build the saturating overflow/underflow statistics counters.
module mp_stream_converter #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mp_stream_converter_if.slave bus,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     ovf_count,
  output logic [CNT_W-1:0]     unf_count
);
  localparam int DW = 8*LANES;

  // FP4 value 0.5 (exp 00, mant 1) widens to an FP8 normal, not a subnormal.
  function automatic logic [7:0] up_conv(input logic [3:0] f);
    logic [7:0] r;
    r = {f[3], 7'b0000000};
    if (f[2:1] == 2'b00) begin
      if (f[0]) r = {f[3], 4'b0110, 3'b000};
    end else begin
      r = {f[3], {2'b00, f[2:1]} + 4'd6, f[0], 2'b00};
    end
    return r;
  endfunction

  // Result packing: {ovf, unf, fp4}. Exponent e-6 is computed as e+2 modulo 4.
  function automatic logic [5:0] down_conv(input logic [7:0] f);
    logic [3:0] e;
    logic [2:0] m;
    logic [1:0] ex;
    logic [3:0] sum;
    logic       rup;
    logic [5:0] r;
    e   = f[6:3];
    m   = f[2:0];
    ex  = e[1:0] + 2'd2;
    rup = m[1] & (m[0] | m[2]);
    sum = {1'b0, ex, m[2]} + {3'b000, rup};
    r   = {2'b00, f[7], 3'b000};
    if (e <= 4'd4) begin
      r[4] = |f[6:0];
    end else if (e == 4'd5) begin
      if (m == 3'b000) r[4] = 1'b1;
      else             r[2:0] = 3'b001;
    end else if (e <= 4'd9 && !sum[3]) begin
      r[2:0] = sum[2:0];
    end else begin
      r = {2'b10, f[7], 3'b111};
    end
    return r;
  endfunction

  logic [DW-1:0]    conv_data;
  logic [LANES-1:0] conv_ovf;
  logic [LANES-1:0] conv_unf;
  logic [5:0]       lane_dn;

  always_comb begin
    conv_data = '0;
    conv_ovf  = '0;
    conv_unf  = '0;
    lane_dn   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.in_mode) begin
        lane_dn            = down_conv(bus.in_data[8*i +: 8]);
        conv_data[4*i +: 4] = lane_dn[3:0];
        conv_ovf[i]        = lane_dn[5];
        conv_unf[i]        = lane_dn[4];
      end else begin
        conv_data[8*i +: 8] = up_conv(bus.in_data[4*i +: 4]);
      end
    end
  end

  logic             s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d;
  logic [DW-1:0]    s1_data_q, s1_data_d;
  logic [LANES-1:0] s1_ovf_q, s1_ovf_d, s1_unf_q, s1_unf_d;
  logic             s2_valid_q, s2_valid_d, s2_mode_q, s2_mode_d;
  logic [DW-1:0]    s2_data_q, s2_data_d;
  logic [LANES-1:0] s2_ovf_q, s2_ovf_d, s2_unf_q, s2_unf_d;
  logic             s1_load, s2_load;

  // A stage loads when empty or when its beat leaves this cycle; payload only moves with a valid beat.
  assign s2_load = !s2_valid_q || bus.out_ready;
  assign s1_load = !s1_valid_q || s2_load;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_data_d  = s1_data_q;
    s1_ovf_d   = s1_ovf_q;
    s1_unf_d   = s1_unf_q;
    s2_valid_d = s2_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    s2_unf_d   = s2_unf_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_d = s1_mode_q;
        s2_data_d = s1_data_q;
        s2_ovf_d  = s1_ovf_q;
        s2_unf_d  = s1_unf_q;
      end
    end
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mode_d = bus.in_mode;
        s1_data_d = conv_data;
        s1_ovf_d  = conv_ovf;
        s1_unf_d  = conv_unf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_ovf_q   <= '0;
      s1_unf_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= '0;
      s2_unf_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_data_q  <= s1_data_d;
      s1_ovf_q   <= s1_ovf_d;
      s1_unf_q   <= s1_unf_d;
      s2_valid_q <= s2_valid_d;
      s2_mode_q  <= s2_mode_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_unf_q   <= s2_unf_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_mode  = s2_mode_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_ovf   = s2_ovf_q;
  assign bus.out_unf   = s2_unf_q;

`ifdef MP_CONV_STATS_EN
  function automatic logic [CNT_W:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + {{CNT_W{1'b0}}, v[i]};
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W:0] b);
    logic [CNT_W+1:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic             out_hs;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d, unf_cnt_q, unf_cnt_d;

  assign out_hs = s2_valid_q && bus.out_ready;

  // A clear that coincides with a handshake restarts the count from that beat.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (stat_clr) begin
      ovf_cnt_d = out_hs ? sat_add({CNT_W{1'b0}}, popcount(s2_ovf_q)) : {CNT_W{1'b0}};
      unf_cnt_d = out_hs ? sat_add({CNT_W{1'b0}}, popcount(s2_unf_q)) : {CNT_W{1'b0}};
    end else if (out_hs) begin
      ovf_cnt_d = sat_add(ovf_cnt_q, popcount(s2_ovf_q));
      unf_cnt_d = sat_add(unf_cnt_q, popcount(s2_unf_q));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
  assign unf_count = unf_cnt_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign ovf_count = '0;
  assign unf_count = '0;
`endif
endmodule

// File: tb/tb_mp_stream_converter.sv
// Directed self-checking bench for mp_stream_converter (4 lanes, 4-bit counters).
// Counter expectations follow MP_CONV_STATS_EN; without it the counters must read zero.
module tb_mp_stream_converter;
`ifdef MP_CONV_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       stat_clr;
  logic [3:0] ovf_count;
  logic [3:0] unf_count;
  int         vectors;
  int         miscompares;

  logic [31:0] vin  [4];
  logic [31:0] vout [4];
  logic        vmode[4];
  logic [3:0]  vov  [4];
  logic [3:0]  vun  [4];

  mp_stream_converter_if #(.LANES(4)) bus ();

  mp_stream_converter #(.LANES(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stat_clr  (stat_clr),
    .ovf_count (ovf_count),
    .unf_count (unf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one beat into an empty pipe and reports the first output beat and its latency.
  task automatic run_beat(input logic mode, input logic [31:0] data, output logic [31:0] od,
                          output logic [3:0] ov, output logic [3:0] un, output logic om, output int lat);
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_data   = data;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0; od = '0; ov = '0; un = '0; om = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k; od = bus.out_data; ov = bus.out_ovf; un = bus.out_unf; om = bus.out_mode;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_data = '0;
    bus.out_ready = 1'b0; stat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_mode !== 1'b0)
      begin miscompares++; $display("FAIL reset_out: valid=%b data=%h mode=%b, need 0/0/0", bus.out_valid, bus.out_data, bus.out_mode); end
    vectors++;
    if (bus.out_ovf !== 4'h0 || bus.out_unf !== 4'h0 || ovf_count !== 4'h0 || unf_count !== 4'h0)
      begin miscompares++; $display("FAIL reset_flags: ovf=%h unf=%h cnt=%h/%h, need 0", bus.out_ovf, bus.out_unf, ovf_count, unf_count); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: in_ready=%b need 1", bus.in_ready); end
  endtask

  task automatic test_up();
    logic [31:0] od; logic [3:0] ov, un; logic om; int lat;
    run_beat(1'b0, 32'h0000F813, od, ov, un, om, lat);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL up_latency: got %0d need 2", lat); end
    vectors++;
    if (od !== 32'hCC80303C || om !== 1'b0)
      begin miscompares++; $display("FAIL up_data: got %h mode %b, need cc80303c mode 0", od, om); end
    vectors++;
    if (ov !== 4'h0 || un !== 4'h0) begin miscompares++; $display("FAIL up_flags: ovf=%h unf=%h need 0/0", ov, un); end
  endtask

  task automatic test_down_round();
    logic [31:0] od; logic [3:0] ov, un; logic om; int lat;
    run_beat(1'b1, 32'h503E3A3C, od, ov, un, om, lat);
    vectors++;
    if (lat !== 2 || od !== 32'h00007423 || om !== 1'b1)
      begin miscompares++; $display("FAIL down_round_data: got %h mode %b lat %0d, need 00007423 mode 1 lat 2", od, om, lat); end
    vectors++;
    if (ov !== 4'b1000 || un !== 4'b0000)
      begin miscompares++; $display("FAIL down_round_flags: ovf=%b unf=%b need 1000/0000", ov, un); end
  endtask

  task automatic test_down_underflow();
    logic [31:0] od; logic [3:0] ov, un; logic om; int lat;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    vectors++;
    if (ovf_count !== 4'd0 || unf_count !== 4'd0)
      begin miscompares++; $display("FAIL stat_clear: ovf=%0d unf=%0d need 0/0", ovf_count, unf_count); end
    run_beat(1'b1, 32'hF800A928, od, ov, un, om, lat);
    vectors++;
    if (od !== 32'h0000F090) begin miscompares++; $display("FAIL down_unf_data: got %h need 0000f090", od); end
    vectors++;
    if (ov !== 4'b1000 || un !== 4'b0001)
      begin miscompares++; $display("FAIL down_unf_flags: ovf=%b unf=%b need 1000/0001", ov, un); end
    vectors++;
    if (ovf_count !== (STATS ? 4'd1 : 4'd0) || unf_count !== (STATS ? 4'd1 : 4'd0))
      begin miscompares++; $display("FAIL down_unf_counts: ovf=%0d unf=%0d need %0d/%0d", ovf_count, unf_count, STATS, STATS); end
  endtask

  task automatic test_back_to_back();
    int sent, recv, occ;
    logic exp_rdy;
    sent = 0; recv = 0; occ = 0;
    for (int cyc = 0; cyc < 300 && recv < 16; cyc++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = (sent < 16);
      bus.in_mode   = vmode[sent % 4];
      bus.in_data   = vin[sent % 4];
      @(negedge clk);
      exp_rdy = !(occ == 2 && !bus.out_ready);
      vectors++;
      if (bus.in_ready !== exp_rdy)
        begin miscompares++; $display("FAIL b2b_ready: cycle %0d in_ready=%b need %b", cyc, bus.in_ready, exp_rdy); end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (bus.out_mode !== vmode[recv % 4] || bus.out_data !== vout[recv % 4] ||
            bus.out_ovf !== vov[recv % 4] || bus.out_unf !== vun[recv % 4])
          begin miscompares++; $display("FAIL b2b_beat%0d: got %b/%h/%b/%b need %b/%h/%b/%b", recv, bus.out_mode, bus.out_data, bus.out_ovf, bus.out_unf, vmode[recv % 4], vout[recv % 4], vov[recv % 4], vun[recv % 4]); end
        recv++; occ--;
      end
      if (bus.in_valid && bus.in_ready) begin sent++; occ++; end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (recv !== 16) begin miscompares++; $display("FAIL b2b_count: received %0d need 16", recv); end
  endtask

  task automatic test_backpressure();
    int acc;
    logic exp_v;
    acc = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = vmode[acc];
      bus.in_data  = vin[acc];
      @(negedge clk);
      if (c >= 2) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== vout[0] || bus.out_mode !== vmode[0])
          begin miscompares++; $display("FAIL bp_hold: cycle %0d valid=%b data=%h need 1/%h", c, bus.out_valid, bus.out_data, vout[0]); end
      end
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
    end
    vectors++;
    if (acc !== 2) begin miscompares++; $display("FAIL bp_accepted: got %0d need 2", acc); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      exp_v = (c < 2);
      vectors++;
      if (bus.out_valid !== exp_v || (exp_v && bus.out_data !== vout[c]))
        begin miscompares++; $display("FAIL bp_drain%0d: valid=%b data=%h need %b/%h", c, bus.out_valid, bus.out_data, exp_v, vout[c]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stats_saturate();
    logic [31:0] od; logic [3:0] ov, un; logic om; int lat;
    int e;
    logic [3:0] exp_cnt;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    for (int b = 0; b < 5; b++) begin
      run_beat(1'b1, 32'h50505050, od, ov, un, om, lat);
      e = 4 * (b + 1);
      if (e > 15) e = 15;
      exp_cnt = STATS ? 4'(e) : 4'd0;
      vectors++;
      if (od !== 32'h00007777 || ov !== 4'hF || un !== 4'h0)
        begin miscompares++; $display("FAIL sat_beat%0d: data=%h ovf=%b unf=%b need 00007777/1111/0000", b, od, ov, un); end
      vectors++;
      if (ovf_count !== exp_cnt || unf_count !== 4'd0)
        begin miscompares++; $display("FAIL sat_count%0d: ovf=%0d unf=%0d need %0d/0", b, ovf_count, unf_count, exp_cnt); end
    end
    bus.in_valid = 1'b1; bus.in_mode = 1'b1; bus.in_data = 32'h50505050; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL clr_hs_valid: out_valid=%b need 1", bus.out_valid); end
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    vectors++;
    if (ovf_count !== (STATS ? 4'd4 : 4'd0))
      begin miscompares++; $display("FAIL clr_hs_count: ovf=%0d need %0d", ovf_count, STATS ? 4 : 0); end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_mode = vmode[0]; bus.in_data = vin[0];
    @(posedge clk); #1;
    bus.in_mode = vmode[1]; bus.in_data = vin[1];
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0)
      begin miscompares++; $display("FAIL mid_reset: valid=%b data=%h need 0/0", bus.out_valid, bus.out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stale_beat: cycle %0d out_valid=%b need 0", c, bus.out_valid); end
      @(posedge clk); #1;
    end
    vectors++;
    if (ovf_count !== 4'd0 || unf_count !== 4'd0)
      begin miscompares++; $display("FAIL mid_reset_counts: ovf=%0d unf=%0d need 0/0", ovf_count, unf_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    vin   = '{32'h0000F813, 32'h503E3A3C, 32'h0000E520, 32'hF800A928};
    vout  = '{32'hCC80303C, 32'h00007423, 32'hC8443800, 32'h0000F090};
    vmode = '{1'b0, 1'b1, 1'b0, 1'b1};
    vov   = '{4'b0000, 4'b1000, 4'b0000, 4'b1000};
    vun   = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
    test_reset();
    test_up();
    test_down_round();
    test_down_underflow();
    test_back_to_back();
    test_backpressure();
    test_stats_saturate();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
